// File: rtl/l1_state_array_if.sv
// Request/response bundle for the L1 MESI state array: per-port read
// requests and responses, the single write port, and flash/status signals.
interface l1_state_array_if #(
  parameter int NUM_SETS     = 64,
  parameter int NUM_WAYS     = 8,
  parameter int NUM_RD_PORTS = 2,
  parameter int STATE_W      = 2
);
  localparam int SET_W = $clog2(NUM_SETS);

  logic [NUM_RD_PORTS-1:0]                            rd_en_mm1;
  logic [NUM_RD_PORTS-1:0][SET_W-1:0]                 rd_set_mm1;
  logic [NUM_RD_PORTS-1:0]                            rd_valid_mm2;
  logic [NUM_RD_PORTS-1:0][NUM_WAYS-1:0][STATE_W-1:0] rd_state_mm2;
  logic                                               wr_en_mm3;
  logic [SET_W-1:0]                                   wr_set_mm3;
  logic [NUM_WAYS-1:0]                                wr_way_mask_mm3;
  logic [STATE_W-1:0]                                 wr_state_mm3;
  logic                                               flash_inv_req;
  logic                                               ready;
  logic                                               flash_inv_done;
  logic                                               wr_err;

  modport master (
    output rd_en_mm1, rd_set_mm1, wr_en_mm3, wr_set_mm3, wr_way_mask_mm3,
           wr_state_mm3, flash_inv_req,
    input  rd_valid_mm2, rd_state_mm2, ready, flash_inv_done, wr_err
  );

  modport slave (
    input  rd_en_mm1, rd_set_mm1, wr_en_mm3, wr_set_mm3, wr_way_mask_mm3,
           wr_state_mm3, flash_inv_req,
    output rd_valid_mm2, rd_state_mm2, ready, flash_inv_done, wr_err
  );
endinterface

// File: rtl/l1_state_array.sv
// L1 MESI state array: multi-port 1-cycle reads with write-first bypass,
// masked single-port writes, and an INIT/FLUSH sweep that invalidates one
// set per cycle.
module l1_state_array #(
  parameter int NUM_SETS     = 64,
  parameter int NUM_WAYS     = 8,
  parameter int NUM_RD_PORTS = 2,
  parameter int STATE_W      = 2,
  parameter int INV_STATE    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  l1_state_array_if.slave  bus
);
  localparam int SET_W = $clog2(NUM_SETS);

  typedef logic [NUM_WAYS-1:0][STATE_W-1:0] line_t;
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_FLUSH} state_t;

  localparam line_t INV_LINE = {NUM_WAYS{STATE_W'(INV_STATE)}};

  state_t                                             r_state;
  state_t                                             w_state_nxt;
  logic [SET_W-1:0]                                   r_cnt;
  logic [SET_W-1:0]                                   w_cnt_nxt;
  logic                                               w_sweep_last;
  logic                                               r_ready;
  logic                                               r_done;
  logic                                               r_wr_err;
  logic                                               w_wr_acc;
  logic [NUM_RD_PORTS-1:0]                            w_rd_acc;
  line_t                                              w_rd_line [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0]                            r_rd_valid;
  logic [NUM_RD_PORTS-1:0][NUM_WAYS-1:0][STATE_W-1:0] r_rd_state;
  line_t                                              r_mem [NUM_SETS];

  assign w_sweep_last = (r_cnt == SET_W'(NUM_SETS - 1));
  assign w_wr_acc     = bus.wr_en_mm3 & r_ready;
  assign w_rd_acc     = bus.rd_en_mm1 & {NUM_RD_PORTS{r_ready}};

  // Next-state and sweep-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_INIT, S_FLUSH: begin
        if (w_sweep_last) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + SET_W'(1);
        end
      end
      S_IDLE: begin
        if (bus.flash_inv_req) w_state_nxt = S_FLUSH;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  // FSM, ready (registered from next state), done and write-error pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_INIT;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ready  <= (w_state_nxt == S_IDLE);
      r_done   <= (r_state == S_FLUSH) && w_sweep_last;
      r_wr_err <= bus.wr_en_mm3 & ~r_ready;
    end
  end

  // Storage: sweep invalidation while not idle, otherwise masked writes.
  always_ff @(posedge clk) begin
    if (r_state != S_IDLE) begin
      r_mem[r_cnt] <= INV_LINE;
    end else if (w_wr_acc) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        if (bus.wr_way_mask_mm3[w]) r_mem[bus.wr_set_mm3][w] <= bus.wr_state_mm3;
      end
    end
  end

  // Per-port read data with write-first bypass on masked ways.
  always_comb begin
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
      w_rd_line[p] = r_mem[bus.rd_set_mm1[p]];
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        if (w_wr_acc && (bus.wr_set_mm3 == bus.rd_set_mm1[p]) && bus.wr_way_mask_mm3[w])
          w_rd_line[p][w] = bus.wr_state_mm3;
      end
    end
  end

  // Read response registers; zero when the read was not accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid <= '0;
      r_rd_state <= '0;
    end else begin
      r_rd_valid <= w_rd_acc;
      for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
        r_rd_state[p] <= w_rd_acc[p] ? w_rd_line[p] : '0;
      end
    end
  end

  assign bus.rd_valid_mm2   = r_rd_valid;
  assign bus.rd_state_mm2   = r_rd_state;
  assign bus.ready          = r_ready;
  assign bus.flash_inv_done = r_done;
  assign bus.wr_err         = r_wr_err;

  a_wr_set_range: assert property (@(posedge clk) disable iff (!reset_n)
    w_wr_acc |-> (32'(bus.wr_set_mm3) < NUM_SETS));

  for (genvar gp = 0; gp < NUM_RD_PORTS; gp++) begin : g_rd_chk
    a_rd_set_range: assert property (@(posedge clk) disable iff (!reset_n)
      w_rd_acc[gp] |-> (32'(bus.rd_set_mm1[gp]) < NUM_SETS));
  end
endmodule

// File: tb/tb_l1_state_array.sv
// Randomized bench for l1_state_array against a set/way array model with a
// busy-cycle countdown standing in for the init/flush sweep.
module tb_l1_state_array;
  localparam int NS = 64;
  localparam int NW = 8;
  localparam int NP = 2;
  localparam int SW = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  l1_state_array_if #(.NUM_SETS(NS), .NUM_WAYS(NW), .NUM_RD_PORTS(NP), .STATE_W(SW)) bus ();

  l1_state_array #(
    .NUM_SETS(NS), .NUM_WAYS(NW), .NUM_RD_PORTS(NP), .STATE_W(SW), .INV_STATE(0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: array contents, remaining sweep edges before ready, sweep kind.
  bit [SW-1:0] m_mem [NS][NW];
  int          busy;
  bit          flushing;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.rd_en_mm1       = '0;
    bus.rd_set_mm1      = '0;
    bus.wr_en_mm3       = 1'b0;
    bus.wr_set_mm3      = '0;
    bus.wr_way_mask_mm3 = '0;
    bus.wr_state_mm3    = '0;
    bus.flash_inv_req   = 1'b0;
  endtask

  function automatic int pick_set();
    return ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, NS - 1);
  endfunction

  task automatic rand_inputs(input bit allow_flash);
    for (int p = 0; p < NP; p++) begin
      bus.rd_en_mm1[p]  = ($urandom_range(0, 3) != 0);
      bus.rd_set_mm1[p] = 6'(pick_set());
    end
    bus.wr_en_mm3       = ($urandom_range(0, 1) == 1);
    bus.wr_set_mm3      = 6'(pick_set());
    bus.wr_way_mask_mm3 = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
    bus.wr_state_mm3    = 2'($urandom_range(0, 3));
    bus.flash_inv_req   = allow_flash && ($urandom_range(0, 299) == 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(bus.ready), 64'd0);
    check({tag, "_done"},  64'(bus.flash_inv_done), 64'd0);
    check({tag, "_wrerr"}, 64'(bus.wr_err), 64'd0);
    check({tag, "_valid"}, 64'(bus.rd_valid_mm2), 64'd0);
    check({tag, "_state"}, 64'(bus.rd_state_mm2), 64'd0);
  endtask

  // One clock: predict from pre-edge model and current inputs, then compare.
  task automatic tick();
    bit                rdy;
    bit                wacc;
    int                rs;
    int                ws;
    logic [SW-1:0]     s;
    logic [NP-1:0]     e_val;
    logic [NW*SW-1:0]  e_dat [NP];
    logic              e_err;
    logic              e_done;
    logic              e_rdy;
    rdy  = (busy == 0);
    wacc = bus.wr_en_mm3 && rdy;
    ws   = int'(bus.wr_set_mm3);
    for (int p = 0; p < NP; p++) begin
      e_val[p] = bus.rd_en_mm1[p] && rdy;
      e_dat[p] = '0;
      rs = int'(bus.rd_set_mm1[p]);
      if (e_val[p]) begin
        for (int w = 0; w < NW; w++) begin
          s = m_mem[rs][w];
          if (wacc && ws == rs && bus.wr_way_mask_mm3[w]) s = bus.wr_state_mm3;
          e_dat[p][w*SW +: SW] = s;
        end
      end
    end
    e_err = bus.wr_en_mm3 && !rdy;
    if (wacc) begin
      for (int w = 0; w < NW; w++)
        if (bus.wr_way_mask_mm3[w]) m_mem[ws][w] = bus.wr_state_mm3;
    end
    e_done = 1'b0;
    if (rdy) begin
      if (bus.flash_inv_req) begin
        busy     = NS;
        flushing = 1'b1;
      end
    end else begin
      busy--;
      if (busy == 0) begin
        e_done   = flushing;
        flushing = 1'b0;
        for (int i = 0; i < NS; i++)
          for (int w = 0; w < NW; w++) m_mem[i][w] = '0;
      end
    end
    e_rdy = (busy == 0);

    @(posedge clk);
    #1;
    check("ready", 64'(bus.ready), 64'(e_rdy));
    check("flash_done", 64'(bus.flash_inv_done), 64'(e_done));
    check("wr_err", 64'(bus.wr_err), 64'(e_err));
    for (int p = 0; p < NP; p++) begin
      check($sformatf("rd_valid%0d", p), 64'(bus.rd_valid_mm2[p]), 64'(e_val[p]));
      check($sformatf("rd_state%0d", p), 64'(bus.rd_state_mm2[p]), 64'(e_dat[p]));
    end
  endtask

  // Asynchronous reset mid-cycle; released just after an edge.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    busy     = NS;
    flushing = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    reset_n = 1'b1;
  endtask

  task automatic rd(input int p, input int set);
    bus.rd_en_mm1[p]  = 1'b1;
    bus.rd_set_mm1[p] = 6'(set);
  endtask

  task automatic wr(input int set, input logic [NW-1:0] mask, input logic [SW-1:0] st);
    bus.wr_en_mm3       = 1'b1;
    bus.wr_set_mm3      = 6'(set);
    bus.wr_way_mask_mm3 = mask;
    bus.wr_state_mm3    = st;
  endtask

  initial begin
    busy     = NS;
    flushing = 1'b0;
    drive_idle();
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    // Init sweep with reads/writes attempted while not ready.
    for (int i = 0; i < NS; i++) begin
      rand_inputs(1'b0);
      tick();
    end

    // Directed: fresh read, masked write, bypass, same-set dual read.
    drive_idle(); rd(0, 5); tick();
    drive_idle(); wr(3, 8'h05, 2'd3); tick();
    drive_idle(); rd(0, 3); tick();
    drive_idle(); wr(7, 8'h80, 2'd2); rd(1, 7); tick();
    drive_idle(); wr(9, 8'h3C, 2'd1); tick();
    drive_idle(); rd(0, 9); rd(1, 9); tick();
    drive_idle(); wr(9, 8'h00, 2'd3); rd(0, 9); tick();

    for (int i = 0; i < 1500; i++) begin
      rand_inputs(1'b1);
      tick();
    end
    while (busy != 0) begin
      rand_inputs(1'b0);
      tick();
    end

    // Populate, flash, write during flush, then read every set back.
    for (int i = 0; i < 40; i++) begin
      drive_idle(); wr(i, 8'($urandom) | 8'h01, 2'($urandom_range(1, 3))); tick();
    end
    drive_idle(); bus.flash_inv_req = 1'b1; tick();
    for (int i = 0; i < NS; i++) begin
      drive_idle();
      if (i % 4 == 0) wr(i % 8, 8'hFF, 2'd3);
      if (i == 10) bus.flash_inv_req = 1'b1;
      tick();
    end
    for (int i = 0; i < NS; i += 2) begin
      drive_idle(); rd(0, i); rd(1, i + 1); tick();
    end

    // Reset in the middle of a flush (after set 20 has been swept).
    for (int i = 0; i < 10; i++) begin
      drive_idle(); wr(20 + i, 8'hFF, 2'd2); tick();
    end
    drive_idle(); bus.flash_inv_req = 1'b1; tick();
    for (int i = 0; i < 21; i++) begin
      drive_idle(); tick();
    end
    do_reset();
    for (int i = 0; i < NS; i++) begin
      drive_idle(); rd(0, 20); tick();
    end
    drive_idle(); rd(0, 25); rd(1, 25); tick();

    for (int i = 0; i < 500; i++) begin
      rand_inputs(1'b1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
